// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction-fetch (I) and data (D) requesters share one memory port.
// D wins ties until the I side has been starved STARVE_MAX consecutive D grants.
//
// state  | meaning
// IDLE   | no memory transaction outstanding; grants are decided here
// I_BUSY | instruction fetch outstanding on the memory port
// D_BUSY | data load/store outstanding on the memory port
// I_DROP | fetch was flushed; wait for memory to finish and discard the data
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int ADR_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IC_REQ_SI,
  input  logic [ADR_W-1:0] IC_ADR_SI,
  input  logic             IF2DEC_FLUSH_SD,
  output logic             IC_ACK_SA,
  output logic [31:0]      IC_DATA_SA,
  input  logic             DC_REQ_SM,
  input  logic             DC_WE_SM,
  input  logic [ADR_W-1:0] DC_ADR_SM,
  input  logic [31:0]      DC_DATA_SM,
  input  logic [3:0]       DC_BE_SM,
  output logic             DC_ACK_SA,
  output logic [31:0]      DC_DATA_SA,
  output logic             MEM_REQ_SA,
  output logic             MEM_WE_SA,
  output logic [ADR_W-1:0] MEM_ADR_SA,
  output logic [31:0]      MEM_DATA_SA,
  output logic [3:0]       MEM_BE_SA,
  input  logic             MEM_ACK_SX,
  input  logic [31:0]      MEM_DATA_SX,
  output logic             ARB_BUSY_SA
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, I_DROP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             armed;
  logic             grant_i, grant_d;
  logic             starved;

  assign starved     = (starve_cnt >= CNT_W'(STARVE_MAX));
  assign ARB_BUSY_SA = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // armed holds off granting on the first edge after reset release
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (armed) begin
          if (DC_REQ_SM && (!IC_REQ_SI || !starved)) grant_d = 1'b1;
          else if (IC_REQ_SI && !IF2DEC_FLUSH_SD)   grant_i = 1'b1;
        end
        if (grant_d)      state_nxt = D_BUSY;
        else if (grant_i) state_nxt = I_BUSY;
      end
      I_BUSY: begin
        if (MEM_ACK_SX)           state_nxt = IDLE;
        else if (IF2DEC_FLUSH_SD) state_nxt = I_DROP;
      end
      D_BUSY:  if (MEM_ACK_SX) state_nxt = IDLE;
      I_DROP:  if (MEM_ACK_SX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed       <= 1'b0;
      starve_cnt  <= '0;
      MEM_REQ_SA  <= 1'b0;
      MEM_WE_SA   <= 1'b0;
      MEM_ADR_SA  <= '0;
      MEM_DATA_SA <= '0;
      MEM_BE_SA   <= '0;
      IC_ACK_SA   <= 1'b0;
      IC_DATA_SA  <= '0;
      DC_ACK_SA   <= 1'b0;
      DC_DATA_SA  <= '0;
    end else begin
      armed      <= 1'b1;
      MEM_REQ_SA <= (state_nxt != IDLE);

      if (!IC_REQ_SI || grant_i)   starve_cnt <= '0;
      else if (grant_d && !starved) starve_cnt <= starve_cnt + CNT_W'(1);

      if (grant_d) begin
        MEM_WE_SA   <= DC_WE_SM;
        MEM_ADR_SA  <= DC_ADR_SM;
        MEM_DATA_SA <= DC_DATA_SM;
        MEM_BE_SA   <= DC_BE_SM;
      end else if (grant_i) begin
        MEM_WE_SA   <= 1'b0;
        MEM_ADR_SA  <= IC_ADR_SI;
        MEM_DATA_SA <= '0;
        MEM_BE_SA   <= 4'hF;
      end

      // a flush in the completion cycle swallows the fetch response
      IC_ACK_SA <= (state == I_BUSY) && MEM_ACK_SX && !IF2DEC_FLUSH_SD;
      DC_ACK_SA <= (state == D_BUSY) && MEM_ACK_SX;
      if ((state == I_BUSY) && MEM_ACK_SX && !IF2DEC_FLUSH_SD) IC_DATA_SA <= MEM_DATA_SX;
      if ((state == D_BUSY) && MEM_ACK_SX)                     DC_DATA_SA <= MEM_DATA_SX;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants/acks, a monitor pops and compares.
module tb_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] data;
    logic [3:0]  be;
  } cmd_t;

  typedef struct packed {
    logic        chk;
    logic [31:0] data;
  } ack_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        IC_REQ_SI = 1'b0;
  logic [31:0] IC_ADR_SI = '0;
  logic        IF2DEC_FLUSH_SD = 1'b0;
  logic        IC_ACK_SA;
  logic [31:0] IC_DATA_SA;
  logic        DC_REQ_SM = 1'b0;
  logic        DC_WE_SM = 1'b0;
  logic [31:0] DC_ADR_SM = '0;
  logic [31:0] DC_DATA_SM = '0;
  logic [3:0]  DC_BE_SM = '0;
  logic        DC_ACK_SA;
  logic [31:0] DC_DATA_SA;
  logic        MEM_REQ_SA;
  logic        MEM_WE_SA;
  logic [31:0] MEM_ADR_SA;
  logic [31:0] MEM_DATA_SA;
  logic [3:0]  MEM_BE_SA;
  logic        MEM_ACK_SX = 1'b0;
  logic [31:0] MEM_DATA_SX = '0;
  logic        ARB_BUSY_SA;

  int   vec_cnt  = 0;
  int   miss_cnt = 0;
  cmd_t cmd_q[$];
  ack_t ic_q[$];
  ack_t dc_q[$];
  cmd_t cur_cmd;
  logic prev_req = 1'b0;

  mem_arbiter #(.STARVE_MAX(4), .ADR_W(32)) dut (
    .clk(clk), .reset(reset),
    .IC_REQ_SI(IC_REQ_SI), .IC_ADR_SI(IC_ADR_SI), .IF2DEC_FLUSH_SD(IF2DEC_FLUSH_SD),
    .IC_ACK_SA(IC_ACK_SA), .IC_DATA_SA(IC_DATA_SA),
    .DC_REQ_SM(DC_REQ_SM), .DC_WE_SM(DC_WE_SM), .DC_ADR_SM(DC_ADR_SM),
    .DC_DATA_SM(DC_DATA_SM), .DC_BE_SM(DC_BE_SM),
    .DC_ACK_SA(DC_ACK_SA), .DC_DATA_SA(DC_DATA_SA),
    .MEM_REQ_SA(MEM_REQ_SA), .MEM_WE_SA(MEM_WE_SA), .MEM_ADR_SA(MEM_ADR_SA),
    .MEM_DATA_SA(MEM_DATA_SA), .MEM_BE_SA(MEM_BE_SA),
    .MEM_ACK_SX(MEM_ACK_SX), .MEM_DATA_SX(MEM_DATA_SX),
    .ARB_BUSY_SA(ARB_BUSY_SA)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    ack_t e;
    cmd_t c;
    #1;
    if (IC_ACK_SA || DC_ACK_SA) check("ack_exclusive", 69'(IC_ACK_SA & DC_ACK_SA), 69'(0));
    if (IC_ACK_SA) begin
      if (ic_q.size() == 0) begin
        vec_cnt++; miss_cnt++;
        $display("FAIL ic_ack_unexpected: got IC_ACK_SA=1 required 0");
      end else begin
        e = ic_q.pop_front();
        check("ic_data", 69'(IC_DATA_SA), 69'(e.data));
      end
    end
    if (DC_ACK_SA) begin
      if (dc_q.size() == 0) begin
        vec_cnt++; miss_cnt++;
        $display("FAIL dc_ack_unexpected: got DC_ACK_SA=1 required 0");
      end else begin
        e = dc_q.pop_front();
        if (e.chk) check("dc_data", 69'(DC_DATA_SA), 69'(e.data));
        else       vec_cnt++;
      end
    end
    c = '{MEM_WE_SA, MEM_ADR_SA, MEM_DATA_SA, MEM_BE_SA};
    if (MEM_REQ_SA && !prev_req) begin
      if (cmd_q.size() == 0) begin
        vec_cnt++; miss_cnt++;
        $display("FAIL grant_unexpected: got MEM_REQ_SA=1 required 0");
      end else begin
        cur_cmd = cmd_q.pop_front();
        check("grant_cmd", 69'(c), 69'(cur_cmd));
      end
    end else if (MEM_REQ_SA) begin
      check("cmd_stable", 69'(c), 69'(cur_cmd));
    end
    prev_req = MEM_REQ_SA;
  end

  task automatic wait_req();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (MEM_REQ_SA) return;
    end
    vec_cnt++; miss_cnt++;
    $display("FAIL wait_req_timeout: got MEM_REQ_SA=0 required 1");
  endtask

  // latency counts cycles from the first MEM_REQ_SA cycle to the MEM_ACK_SX cycle
  task automatic mem_serve(input int lat, input logic [31:0] d);
    wait_req();
    repeat (lat - 1) @(negedge clk);
    MEM_ACK_SX = 1'b1; MEM_DATA_SX = d;
    @(negedge clk);
    MEM_ACK_SX = 1'b0; MEM_DATA_SX = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    check("reset_ctl", 69'({MEM_REQ_SA, IC_ACK_SA, DC_ACK_SA, ARB_BUSY_SA}), 69'(0));
    check("reset_data", 69'({IC_DATA_SA, DC_DATA_SA}), 69'(0));
    check("reset_cmd", 69'({MEM_WE_SA, MEM_ADR_SA, MEM_DATA_SA, MEM_BE_SA}), 69'(0));

    // instruction fetch, latency 3; first grant on second edge after release
    reset = 1'b0;
    IC_REQ_SI = 1'b1; IC_ADR_SI = 32'h100;
    cmd_q.push_back('{1'b0, 32'h100, 32'h0, 4'hF});
    ic_q.push_back('{1'b1, 32'h13});
    @(posedge clk); #1 check("first_edge_no_grant", 69'(MEM_REQ_SA), 69'(0));
    @(posedge clk); #1 check("second_edge_grant", 69'(MEM_REQ_SA), 69'(1));
    mem_serve(3, 32'h13);
    IC_REQ_SI = 1'b0;
    @(negedge clk);

    // store
    DC_REQ_SM = 1'b1; DC_WE_SM = 1'b1; DC_ADR_SM = 32'h2000;
    DC_DATA_SM = 32'hDEADBEEF; DC_BE_SM = 4'hF;
    cmd_q.push_back('{1'b1, 32'h2000, 32'hDEADBEEF, 4'hF});
    dc_q.push_back('{1'b0, 32'h0});
    mem_serve(4, 32'h0);
    DC_REQ_SM = 1'b0;
    @(negedge clk);

    // load, latency 1
    DC_REQ_SM = 1'b1; DC_WE_SM = 1'b0; DC_ADR_SM = 32'h3004;
    DC_DATA_SM = 32'h0; DC_BE_SM = 4'h3;
    cmd_q.push_back('{1'b0, 32'h3004, 32'h0, 4'h3});
    dc_q.push_back('{1'b1, 32'hCAFEF00D});
    mem_serve(1, 32'hCAFEF00D);
    DC_REQ_SM = 1'b0;
    @(negedge clk);

    // starvation: D,D,D,D then I, then D again once I is gone
    DC_REQ_SM = 1'b1; DC_WE_SM = 1'b0; DC_ADR_SM = 32'h4000; DC_BE_SM = 4'hF;
    IC_REQ_SI = 1'b1; IC_ADR_SI = 32'h600;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        cmd_q.push_back('{1'b0, 32'h600, 32'h0, 4'hF});
        ic_q.push_back('{1'b1, 32'h1000 + k});
      end else begin
        cmd_q.push_back('{1'b0, 32'h4000, 32'h0, 4'hF});
        dc_q.push_back('{1'b1, 32'h1000 + k});
      end
    end
    for (int k = 0; k < 6; k++) begin
      mem_serve(2, 32'h1000 + k);
      if (k == 3) check("starve_cnt_sat", 69'(dut.starve_cnt), 69'(4));
      if (k == 4) begin
        check("starve_cnt_clear", 69'(dut.starve_cnt), 69'(0));
        IC_REQ_SI = 1'b0;
      end
    end
    DC_REQ_SM = 1'b0;
    @(negedge clk);

    // flush in I_BUSY, ack two cycles later, then a normal fetch
    IC_REQ_SI = 1'b1; IC_ADR_SI = 32'h200;
    cmd_q.push_back('{1'b0, 32'h200, 32'h0, 4'hF});
    wait_req();
    IF2DEC_FLUSH_SD = 1'b1; IC_REQ_SI = 1'b0;
    @(negedge clk);
    IF2DEC_FLUSH_SD = 1'b0;
    check("drop_req_held1", 69'({MEM_REQ_SA, ARB_BUSY_SA}), 69'(3));
    @(negedge clk);
    check("drop_req_held2", 69'({MEM_REQ_SA, ARB_BUSY_SA}), 69'(3));
    MEM_ACK_SX = 1'b1; MEM_DATA_SX = 32'hBAD0BAD0;
    @(negedge clk);
    MEM_ACK_SX = 1'b0; MEM_DATA_SX = '0;
    check("drop_done", 69'({MEM_REQ_SA, ARB_BUSY_SA}), 69'(0));
    IC_REQ_SI = 1'b1; IC_ADR_SI = 32'h204;
    cmd_q.push_back('{1'b0, 32'h204, 32'h0, 4'hF});
    ic_q.push_back('{1'b1, 32'h55});
    mem_serve(2, 32'h55);
    IC_REQ_SI = 1'b0;
    @(negedge clk);

    // flush coincident with memory ack
    IC_REQ_SI = 1'b1; IC_ADR_SI = 32'h300;
    cmd_q.push_back('{1'b0, 32'h300, 32'h0, 4'hF});
    wait_req();
    @(negedge clk);
    MEM_ACK_SX = 1'b1; MEM_DATA_SX = 32'h77; IF2DEC_FLUSH_SD = 1'b1; IC_REQ_SI = 1'b0;
    @(negedge clk);
    MEM_ACK_SX = 1'b0; MEM_DATA_SX = '0; IF2DEC_FLUSH_SD = 1'b0;
    check("flush_ack_idle", 69'({MEM_REQ_SA, ARB_BUSY_SA, IC_ACK_SA}), 69'(0));
    @(negedge clk);

    // reset during D_BUSY
    DC_REQ_SM = 1'b1; DC_WE_SM = 1'b0; DC_ADR_SM = 32'h5000; DC_BE_SM = 4'hF;
    cmd_q.push_back('{1'b0, 32'h5000, 32'h0, 4'hF});
    wait_req();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_ctl", 69'({MEM_REQ_SA, IC_ACK_SA, DC_ACK_SA, ARB_BUSY_SA}), 69'(0));
    check("rst_mid_cmd", 69'({MEM_WE_SA, MEM_ADR_SA, MEM_DATA_SA, MEM_BE_SA}), 69'(0));
    check("rst_mid_data", 69'({IC_DATA_SA, DC_DATA_SA}), 69'(0));
    DC_REQ_SM = 1'b0;
    @(negedge clk);
    MEM_ACK_SX = 1'b1; MEM_DATA_SX = 32'h99;
    @(negedge clk);
    MEM_ACK_SX = 1'b0; MEM_DATA_SX = '0;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_idle", 69'({MEM_REQ_SA, ARB_BUSY_SA, DC_ACK_SA}), 69'(0));

    check("cmd_q_drained", 69'(cmd_q.size()), 69'(0));
    check("ic_q_drained", 69'(ic_q.size()), 69'(0));
    check("dc_q_drained", 69'(dc_q.size()), 69'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
